// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: port identifiers used for
// the grant, the lock owner and the pending read return.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_P0   = 2'd1,
        PORT_P1   = 2'd2
    } port_id_e;

    // Request line of the port named by k; PORT_NONE never requests.
    function automatic logic port_req(input port_id_e k, input logic r0, input logic r1);
        logic req;
        case (k)
            PORT_P0: req = r0;
            PORT_P1: req = r1;
            default: req = 1'b0;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester-side RAM access port: request fields in, grant and read return out.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  req;
    logic                  lock;
    logic                  store;
    logic                  bytemode;
    logic [ADDR_WIDTH-1:0] address;
    logic [15:0]           data_in;
    logic                  gnt;
    logic                  rvalid;
    logic [15:0]           data_out;

    modport master (
        output req, lock, store, bytemode, address, data_in,
        input  gnt, rvalid, data_out
    );

    modport slave (
        input  req, lock, store, bytemode, address, data_in,
        output gnt, rvalid, data_out
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one RAM between the CPU port (p0, fixed priority) and the debug/loader
// port (p1, starvation-bounded), with an optional lock for read-modify-write.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WAIT   = 8,
    parameter int WAIT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_arbiter_if.slave          p0,
    ram_arbiter_if.slave          p1,
    output logic                  ram_store,
    output logic                  ram_bytemode,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [15:0]           ram_data_in,
    input  logic [15:0]           ram_data_out
);

    localparam logic [WAIT_WIDTH-1:0] W_MAX_WAIT = WAIT_WIDTH'(MAX_WAIT);
    localparam logic [WAIT_WIDTH-1:0] W_ONE      = {{(WAIT_WIDTH-1){1'b0}}, 1'b1};

    port_id_e              r_owner;
    port_id_e              r_rd_port;
    logic [WAIT_WIDTH-1:0] r_wait_cnt;

    port_id_e              w_owner_live;
    port_id_e              w_gnt;
    logic                  w_gnt_lock;
    logic                  w_gnt_store;

    // A lock only counts while its owner keeps requesting; a dropped request abandons it.
    always_comb begin
        w_owner_live = PORT_NONE;
        if (port_req(r_owner, p0.req, p1.req)) begin
            w_owner_live = r_owner;
        end else begin
            w_owner_live = PORT_NONE;
        end
    end

    // Grant priority: live lock owner, starved p1, p0, p1.
    always_comb begin
        w_gnt = PORT_NONE;
        if (reset) begin
            w_gnt = PORT_NONE;
        end else if (w_owner_live != PORT_NONE) begin
            w_gnt = w_owner_live;
        end else if (p1.req && (r_wait_cnt == W_MAX_WAIT)) begin
            w_gnt = PORT_P1;
        end else if (p0.req) begin
            w_gnt = PORT_P0;
        end else if (p1.req) begin
            w_gnt = PORT_P1;
        end else begin
            w_gnt = PORT_NONE;
        end
    end

    // Route the granted port onto the RAM; an idle cycle is a harmless read of address 0.
    always_comb begin
        ram_store    = 1'b0;
        ram_bytemode = 1'b0;
        ram_address  = {ADDR_WIDTH{1'b0}};
        ram_data_in  = 16'h0000;
        w_gnt_lock   = 1'b0;
        w_gnt_store  = 1'b0;
        case (w_gnt)
            PORT_P0: begin
                ram_store    = p0.store;
                ram_bytemode = p0.bytemode;
                ram_address  = p0.address;
                ram_data_in  = p0.data_in;
                w_gnt_lock   = p0.lock;
                w_gnt_store  = p0.store;
            end
            PORT_P1: begin
                ram_store    = p1.store;
                ram_bytemode = p1.bytemode;
                ram_address  = p1.address;
                ram_data_in  = p1.data_in;
                w_gnt_lock   = p1.lock;
                w_gnt_store  = p1.store;
            end
            default: begin
                ram_store    = 1'b0;
                ram_bytemode = 1'b0;
                ram_address  = {ADDR_WIDTH{1'b0}};
                ram_data_in  = 16'h0000;
                w_gnt_lock   = 1'b0;
                w_gnt_store  = 1'b0;
            end
        endcase
    end

    assign p0.gnt      = (w_gnt == PORT_P0);
    assign p1.gnt      = (w_gnt == PORT_P1);
    assign p0.rvalid   = (r_rd_port == PORT_P0) && !reset;
    assign p1.rvalid   = (r_rd_port == PORT_P1) && !reset;
    assign p0.data_out = ram_data_out;
    assign p1.data_out = ram_data_out;

    // Lock owner, pending read return and p1 starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= PORT_NONE;
            r_rd_port  <= PORT_NONE;
            r_wait_cnt <= {WAIT_WIDTH{1'b0}};
        end else begin
            // Any non-locking grant (or no grant at all) leaves the RAM unowned.
            r_owner   <= w_gnt_lock ? w_gnt : PORT_NONE;
            r_rd_port <= ((w_gnt != PORT_NONE) && !w_gnt_store) ? w_gnt : PORT_NONE;
            if (!p1.req || (w_gnt == PORT_P1)) begin
                r_wait_cnt <= {WAIT_WIDTH{1'b0}};
            end else if ((w_owner_live == PORT_P0) || (r_wait_cnt == W_MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt;
            end else begin
                r_wait_cnt <= r_wait_cnt + W_ONE;
            end
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one `ram` instance between two requesters: port 0 is the CPU memory port and port 1 is the debug/loader port.
- Port 0 has fixed priority. A wait counter bounds how long port 1 can be starved.
- A lock lets one port hold the RAM across a read-modify-write sequence, as MSP430 memory-destination ops need.
- Sits between the CPU/loader and the RAM; drives the RAM's store, bytemode, address and data_in directly.

Parameters:
- ADDR_WIDTH, 12, byte address width; matches the RAM.
- MAX_WAIT, 8, cycles port 1 may be refused before its request is forced through (1..255).
- WAIT_WIDTH, 8, width of the wait counter; must satisfy MAX_WAIT < 2**WAIT_WIDTH.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held with its fields stable until granted.
- p0_lock  in  1  keep ownership after this access.
- p0_store  in  1  1 = write, 0 = read.
- p0_bytemode  in  1  byte access.
- p0_address  in  ADDR_WIDTH  byte address.
- p0_data_in  in  16  write data (byte data in bits 7:0).
- p0_gnt  out  1  access accepted this cycle.
- p0_rvalid  out  1  read data valid; pulses the cycle after a granted read.
- p0_data_out  out  16  read data; meaningful only while p0_rvalid is high.
- p1_*  same set as port 0.
- ram_store  out  1  to RAM store.
- ram_bytemode  out  1  to RAM bytemode.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_data_in  out  16  to RAM data_in.
- ram_data_out  in  16  from RAM data_out.

Behaviour:
- Grant decision:
  - Combinational from the current requests and registered state, one grant per cycle.
  - The granted port's fields are muxed onto the ram_* outputs in the same cycle; the RAM samples them at the next edge.
- No grant: ram_store=0, ram_bytemode=0, ram_address=0, ram_data_in=0 (harmless RAM read).
- Priority order, first match wins:
  1. reset high: no grant.
  2. Lock owner k valid and pk_req=1: grant k.
  3. No lock owner, p1_req=1 and wait_cnt==MAX_WAIT: grant p1.
  4. p0_req=1: grant p0.
  5. p1_req=1: grant p1.
- A port refused because the other port owns the lock waits.
- Lock owner register (NONE/P0/P1, reset NONE):
  - Set to k when k is granted with pk_lock=1.
  - Cleared when the owner is granted with pk_lock=0, or when the owner's pk_req is low for a cycle (abandoned lock).
- Wait counter:
  - Increments, saturating at MAX_WAIT, each cycle p1_req=1 and p1_gnt=0.
  - Cleared to 0 on p1_gnt, on p1_req=0, or on reset.
  - Is not incremented while port 0 holds the lock, so a port-0 lock can delay port 1 indefinitely. This is deliberate; lock users keep sequences short.
- Read return:
  - Registered rd_port (NONE/P0/P1, reset NONE) records a granted read.
  - pk_rvalid = (rd_port==k), high for exactly one cycle.
  - Both p0_data_out and p1_data_out wire to ram_data_out.
  - Back-to-back reads on alternating ports each get one rvalid pulse, in grant order.
- Writes: no response beyond pk_gnt; the write completes at the edge following the grant.
- Read-after-write to the same address on consecutive grants returns the new data, because the RAM is written at edge N and read at edge N+1.
- Reset values: all gnt=0, all rvalid=0, lock owner NONE, wait_cnt=0, rd_port NONE. Reset asserted mid-read suppresses that read's rvalid.
- Simultaneous requests with no lock and wait_cnt<MAX_WAIT: p0 wins, p1 waits and its counter advances.
- Bytemode and address[0] pass through untouched; byte lane steering stays in the RAM.

Decomposition:
- Shared package holds the port-id constants (PORT_NONE=2'd0, PORT_P0=2'd1, PORT_P1=2'd2), reused for lock owner and rd_port.
- No sub-module: the grant logic and the output mux stay in one module. The RAM is instantiated by the parent, not inside this block.

Test Plan:
- Read return: p0 writes 0x1234 to address 0x010, then reads 0x010. Required: p0_gnt=1 on both cycles, p0_rvalid=1 exactly one cycle after the read grant, p0_data_out=0x1234.
- Simultaneous requests: p0 and p1 both request with MAX_WAIT=8. Required: p0 granted first; p1 granted the cycle p0_req drops.
- Starvation bound: p0_req held high with new reads every cycle and p1_req high. Required: p1_gnt asserts exactly on the 9th cycle, then p0 resumes.
- Lock: p1 reads 0x020 with p1_lock=1 while p0 requests. Required: p0 blocked until p1 writes 0x020 with p1_lock=0; p0 granted the next cycle.
- Abandoned lock: p0 locks, then drops p0_req for one cycle. Required: lock owner returns to NONE and a pending p1 is granted in that same cycle.
- Reset: reset asserted the cycle after a p1 read grant. Required: p1_rvalid stays 0, lock and counters clear, ram_store=0 throughout reset.
